lsu_stage: RTL and testbench

- Load/store unit sitting directly downstream of the execute stage. It is the consumer end of the EXU output handshake.
- Accepts one instruction at a time via in_valid/in_ready, together with the EXU memory controls (need_lsu, mem_wen, mem_ren, wmask, load_ctrl), the address (EXU result) and the store data.
- For memory ops it runs a single-beat request/response bus transaction, aligns store data and strobes, and sign/zero-extends load data.
- Presents the writeback value to the WBU via out_valid/out_ready. Non-memory instructions pass through unchanged.

---
 rtl/lsu_stage_pkg.sv | 49 ++++
 rtl/lsu_align.sv | 68 ++++++
 rtl/lsu_stage.sv | 177 +++++++++++++++++
 tb/tb_lsu_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_stage_pkg.sv
// lsu_stage_pkg: shared definitions for the load/store stage.
// Holds the FSM state encoding, the load funct3 codes, the store mask codes
// and a helper that decides whether an access is misaligned for its size.
package lsu_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] WMASK_B = 4'b0001;
    localparam logic [3:0] WMASK_H = 4'b0011;
    localparam logic [3:0] WMASK_W = 4'b1111;

    // Stores are sized by their mask, loads by funct3; unknown load codes
    // behave as word loads, so they are also sized as words here.
    function automatic logic access_misaligned(
        input logic       is_store,
        input logic [3:0] wmask,
        input logic [2:0] load_ctrl,
        input logic [1:0] offset
    );
        logic result;
        result = 1'b0;
        if (is_store) begin
            if (wmask == WMASK_H) begin
                result = offset[0];
            end else if (wmask == WMASK_W) begin
                result = (offset != 2'b00);
            end
        end else begin
            case (load_ctrl)
                F3_LB, F3_LBU: result = 1'b0;
                F3_LH, F3_LHU: result = offset[0];
                default:       result = (offset != 2'b00);
            endcase
        end
        return result;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store stage.
// Store side shifts data and strobes up to the addressed lane (bits shifted
// past lane 3 are dropped). Load side rotates the response word so the
// addressed lane lands in byte 0 (a half at offset 3 wraps into lane 0),
// then sign- or zero-extends according to funct3.
module lsu_align
    import lsu_stage_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [3:0]  wmask,
    input  logic [31:0] wdata,
    input  logic [2:0]  load_ctrl,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_aligned,
    output logic [31:0] load_data
);

    logic [31:0] rotated;

    // Shift store strobes and data left by whole lanes, truncating to the word.
    always_comb begin
        wstrb         = wmask;
        wdata_aligned = wdata;
        case (offset)
            2'd1: begin
                wstrb         = {wmask[2:0], 1'b0};
                wdata_aligned = {wdata[23:0], 8'h00};
            end
            2'd2: begin
                wstrb         = {wmask[1:0], 2'b00};
                wdata_aligned = {wdata[15:0], 16'h0000};
            end
            2'd3: begin
                wstrb         = {wmask[0], 3'b000};
                wdata_aligned = {wdata[7:0], 24'h000000};
            end
            default: begin
                wstrb         = wmask;
                wdata_aligned = wdata;
            end
        endcase
    end

    // Rotate the read word right by whole lanes so the addressed byte is lane 0.
    always_comb begin
        rotated = rdata;
        case (offset)
            2'd1:    rotated = {rdata[7:0],  rdata[31:8]};
            2'd2:    rotated = {rdata[15:0], rdata[31:16]};
            2'd3:    rotated = {rdata[23:0], rdata[31:24]};
            default: rotated = rdata;
        endcase
    end

    // Extend the selected byte/half; unknown codes return the whole word.
    always_comb begin
        load_data = rotated;
        case (load_ctrl)
            F3_LB:   load_data = {{24{rotated[7]}}, rotated[7:0]};
            F3_LH:   load_data = {{16{rotated[15]}}, rotated[15:0]};
            F3_LBU:  load_data = {24'h000000, rotated[7:0]};
            F3_LHU:  load_data = {16'h0000, rotated[15:0]};
            default: load_data = rotated;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// lsu_stage: load/store unit between execute and writeback.
// Takes one instruction at a time, runs a single-beat bus request/response
// for loads and stores, and hands the result to writeback. Non-memory
// instructions pass the execute result straight through.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses skip the
// bus and complete immediately with lsu_err set.
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32   // byte-lane logic is fixed at 4 lanes, keep at 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  need_lsu,
    input  logic                  mem_wen,
    input  logic                  mem_ren,
    input  logic [3:0]            wmask,
    input  logic [2:0]            load_ctrl,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [4:0]            rd_in,
    input  logic                  reg_wen_in,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_we,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_wdata,
    output logic [3:0]            req_wstrb,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  rsp_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [4:0]            rd_out,
    output logic                  reg_wen_out,
    output logic                  lsu_err
);

    lsu_state_t state;
    lsu_state_t state_next;

    logic        accept;
    logic        is_mem_in;
    logic        trap_in;
    logic        is_store_q;
    logic        reg_wen_q;
    logic [2:0]  load_ctrl_q;
    logic [1:0]  align_offset;
    logic [3:0]  align_wstrb;
    logic [31:0] align_wdata;
    logic [31:0] align_load;

    assign accept    = in_valid && in_ready;
    // A memory op needs at least one of load/store; otherwise it passes through.
    assign is_mem_in = need_lsu && (mem_wen || mem_ren);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_in = is_mem_in && access_misaligned(mem_wen, wmask, load_ctrl, addr_in[1:0]);
`else
    assign trap_in = 1'b0;
`endif

    assign in_ready  = (state == ST_IDLE);
    assign req_valid = (state == ST_REQ);
    assign out_valid = (state == ST_DONE);

    // The aligner serves the store path at accept and the load path at response.
    assign align_offset = (state == ST_IDLE) ? addr_in[1:0] : req_addr[1:0];

    lsu_align u_align (
        .offset        (align_offset),
        .wmask         (wmask),
        .wdata         (wdata_in),
        .load_ctrl     (load_ctrl_q),
        .rdata         (rsp_rdata),
        .wstrb         (align_wstrb),
        .wdata_aligned (align_wdata),
        .load_data     (align_load)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one bus beat per memory op, otherwise straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (is_mem_in && !trap_in) ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (req_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rsp_valid) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: latch the instruction at accept, fill in the result at response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            is_store_q  <= 1'b0;
            reg_wen_q   <= 1'b0;
            load_ctrl_q <= '0;
            req_we      <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            req_wstrb   <= '0;
            out_data    <= '0;
            pc_out      <= '0;
            rd_out      <= '0;
            reg_wen_out <= 1'b0;
            lsu_err     <= 1'b0;
        end else begin
            if (accept) begin
                pc_out      <= pc_in;
                rd_out      <= rd_in;
                reg_wen_q   <= reg_wen_in;
                load_ctrl_q <= load_ctrl;
                is_store_q  <= mem_wen;
                lsu_err     <= 1'b0;
                if (!is_mem_in) begin
                    out_data    <= addr_in;
                    reg_wen_out <= reg_wen_in;
                end else if (trap_in) begin
                    out_data    <= addr_in;
                    reg_wen_out <= 1'b0;
                    lsu_err     <= 1'b1;
                end else begin
                    req_we      <= mem_wen;
                    req_addr    <= addr_in;
                    req_wdata   <= mem_wen ? align_wdata : 32'h0;
                    req_wstrb   <= mem_wen ? align_wstrb : 4'h0;
                    reg_wen_out <= 1'b0;
                end
            end else if ((state == ST_WAIT) && rsp_valid) begin
                if (rsp_err) begin
                    out_data    <= req_addr;
                    reg_wen_out <= 1'b0;
                    lsu_err     <= 1'b1;
                end else if (is_store_q) begin
                    out_data    <= '0;
                    reg_wen_out <= 1'b0;
                end else begin
                    out_data    <= align_load;
                    reg_wen_out <= reg_wen_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: randomized self-checking bench for lsu_stage with a
// behavioural reference model and directed literal checks.
`timescale 1ns/1ps
module tb_lsu_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic        need_lsu, mem_wen, mem_ren;
    logic [3:0]  wmask;
    logic [2:0]  load_ctrl;
    logic [31:0] addr_in, wdata_in, pc_in;
    logic [4:0]  rd_in;
    logic        reg_wen_in;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_data, pc_out;
    logic [4:0]  rd_out;
    logic        reg_wen_out, lsu_err;

    always #5 clock = ~clock;

    lsu_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .need_lsu(need_lsu), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .wmask(wmask), .load_ctrl(load_ctrl),
        .addr_in(addr_in), .wdata_in(wdata_in), .pc_in(pc_in),
        .rd_in(rd_in), .reg_wen_in(reg_wen_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .pc_out(pc_out), .rd_out(rd_out), .reg_wen_out(reg_wen_out),
        .lsu_err(lsu_err)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct {
        bit        need_lsu, wen, ren;
        bit [3:0]  wmask;
        bit [2:0]  lctrl;
        bit [31:0] addr, wdata, pc, rdata;
        bit [4:0]  rd;
        bit        regwen, err;
        int        req_delay, rsp_delay, out_delay;
    } txn_t;

    typedef struct {
        bit        bus, we, reg_wen, err;
        bit [31:0] addr, wdata, out_data, pc;
        bit [3:0]  wstrb;
        bit [4:0]  rd;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t cur_exp;
    bit   exp_active = 1'b0;

    bit        cap_req_seen, cap_we, cap_regwen, cap_err;
    bit [3:0]  cap_wstrb;
    bit [31:0] cap_wdata, cap_data;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_checks++;
        if (actual !== required) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, actual, required, $time);
        end
    endtask

    // Reference model: result of one instruction from the architectural rules.
    function automatic exp_t model(input txn_t t);
        exp_t      e;
        int        off, size;
        bit [63:0] wide;
        bit [31:0] v;
        e.bus = 0; e.we = 0; e.reg_wen = 0; e.err = 0;
        e.addr = 0; e.wdata = 0; e.out_data = 0; e.wstrb = 0;
        e.pc = t.pc; e.rd = t.rd;
        off = int'(t.addr % 32'd4);
        if (!(t.need_lsu && (t.wen || t.ren))) begin
            e.out_data = t.addr;
            e.reg_wen  = t.regwen;
            return e;
        end
        if (t.wen) size = (t.wmask == 4'hF) ? 4 : (t.wmask == 4'h3) ? 2 : 1;
        else size = (t.lctrl == 3'd0 || t.lctrl == 3'd4) ? 1 :
                    (t.lctrl == 3'd1 || t.lctrl == 3'd5) ? 2 : 4;
        if (TRAP_EN && (off % size != 0)) begin
            e.err = 1; e.out_data = t.addr;
            return e;
        end
        e.bus = 1; e.we = t.wen; e.addr = t.addr;
        if (t.wen) begin
            wide    = 64'(t.wmask) << off;
            e.wstrb = wide[3:0];
            wide    = 64'(t.wdata) << (8 * off);
            e.wdata = wide[31:0];
        end
        if (t.err) begin
            e.err = 1; e.out_data = t.addr;
        end else if (!t.wen) begin
            v = 0;
            for (int i = 0; i < size; i++)
                v = v | (((t.rdata >> (8 * ((off + i) % 4))) & 32'hFF) << (8 * i));
            if (t.lctrl == 3'd0 && v >= 32'h80)   v = v + 32'hFFFFFF00;
            if (t.lctrl == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF0000;
            e.out_data = v;
            e.reg_wen  = t.regwen;
        end
        return e;
    endfunction

    function automatic txn_t makeTxn(input bit nl, input bit w, input bit r, input bit [3:0] m,
                                     input bit [2:0] lc, input bit [31:0] a, input bit [31:0] wd,
                                     input bit [31:0] rdat, input bit er);
        txn_t t;
        t.need_lsu = nl; t.wen = w; t.ren = r; t.wmask = m; t.lctrl = lc;
        t.addr = a; t.wdata = wd; t.rdata = rdat; t.err = er;
        t.pc = $urandom; t.rd = 5'($urandom_range(1, 31)); t.regwen = 1'b1;
        t.req_delay = 0; t.rsp_delay = 0; t.out_delay = 0;
        return t;
    endfunction

    function automatic txn_t randTxn();
        txn_t t;
        int   kind, mk;
        kind = int'($urandom_range(0, 4));
        mk   = int'($urandom_range(0, 2));
        t = makeTxn(kind != 0, kind == 3 || kind == 4, kind == 2 || kind == 4,
                    (mk == 0) ? 4'h1 : (mk == 1) ? 4'h3 : 4'hF,
                    3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                    ($urandom_range(0, 7) == 0));
        t.regwen    = 1'($urandom_range(0, 1));
        t.req_delay = int'($urandom_range(0, 3));
        t.rsp_delay = int'($urandom_range(0, 3));
        t.out_delay = int'($urandom_range(0, 3));
        return t;
    endfunction

    // Compare process: check live outputs against the model on every falling edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid) begin
                checkOutput("out_expected", 32'(exp_active), 32'd1);
                if (exp_active) begin
                    checkOutput("out_data", out_data, cur_exp.out_data);
                    checkOutput("reg_wen_out", 32'(reg_wen_out), 32'(cur_exp.reg_wen));
                    checkOutput("lsu_err", 32'(lsu_err), 32'(cur_exp.err));
                    checkOutput("pc_out", pc_out, cur_exp.pc);
                    checkOutput("rd_out", 32'(rd_out), 32'(cur_exp.rd));
                end
            end
            if (req_valid) begin
                checkOutput("req_expected", 32'(exp_active && cur_exp.bus), 32'd1);
                if (exp_active && cur_exp.bus) begin
                    checkOutput("req_we", 32'(req_we), 32'(cur_exp.we));
                    checkOutput("req_addr", req_addr, cur_exp.addr);
                    if (cur_exp.we) begin
                        checkOutput("req_wstrb", 32'(req_wstrb), 32'(cur_exp.wstrb));
                        checkOutput("req_wdata", req_wdata, cur_exp.wdata);
                    end
                end
            end
            checkOutput("in_ready_exclusive", 32'(in_ready && (req_valid || out_valid)), 32'd0);
        end
    end

    // Drive one instruction through accept, bus beat and writeback handshake.
    task automatic applyStimulus(input txn_t t);
        int cnt;
        cur_exp = model(t);
        exp_active = 1'b1;
        cap_req_seen = 1'b0;
        need_lsu = t.need_lsu; mem_wen = t.wen; mem_ren = t.ren;
        wmask = t.wmask; load_ctrl = t.lctrl; addr_in = t.addr;
        wdata_in = t.wdata; pc_in = t.pc; rd_in = t.rd; reg_wen_in = t.regwen;
        in_valid = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 50) begin @(posedge clock); #1; cnt++; end
        checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        need_lsu = 1'($urandom); mem_wen = 1'($urandom); mem_ren = 1'($urandom);
        addr_in = $urandom; wdata_in = $urandom; pc_in = $urandom; wmask = 4'($urandom);
        if (cur_exp.bus) begin
            checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
            cnt = 0;
            while (!req_valid && cnt < 20) begin @(posedge clock); #1; cnt++; end
            checkOutput("req_valid_timeout", 32'(req_valid), 32'd1);
            cap_req_seen = req_valid; cap_we = req_we;
            cap_wstrb = req_wstrb; cap_wdata = req_wdata;
            repeat (t.req_delay) begin @(posedge clock); #1; end
            req_ready = 1'b1;
            @(posedge clock); #1;
            req_ready = 1'b0;
            checkOutput("req_drop", 32'(req_valid), 32'd0);
            repeat (t.rsp_delay) begin @(posedge clock); #1; end
            rsp_valid = 1'b1; rsp_rdata = t.rdata; rsp_err = t.err;
            @(posedge clock); #1;
            rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = $urandom;
        end
        checkOutput("out_latency", 32'(out_valid), 32'd1);
        repeat (t.out_delay) begin
            rsp_valid = 1'($urandom); rsp_err = 1'($urandom); rsp_rdata = $urandom;
            @(posedge clock); #1;
        end
        rsp_valid = 1'b0; rsp_err = 1'b0;
        cap_data = out_data; cap_regwen = reg_wen_out; cap_err = lsu_err;
        out_ready = 1'b1;
        cnt = 0;
        while (!out_valid && cnt < 20) begin @(posedge clock); #1; cnt++; end
        @(posedge clock); #1;
        out_ready = 1'b0;
        exp_active = 1'b0;
        checkOutput("in_ready_after_done", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        txn_t t;
        reset = 1'b1;
        in_valid = 0; need_lsu = 0; mem_wen = 0; mem_ren = 0; wmask = 0; load_ctrl = 0;
        addr_in = 0; wdata_in = 0; pc_in = 0; rd_in = 0; reg_wen_in = 0;
        req_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; out_ready = 0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_req_valid", 32'(req_valid), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // ALU passthrough
        t = makeTxn(0, 0, 0, 4'h1, 3'd0, 32'h1234, 32'h0, 32'h0, 0);
        applyStimulus(t);
        checkOutput("alu_data_literal", cap_data, 32'h0000_1234);
        checkOutput("alu_no_req", 32'(cap_req_seen), 32'd0);

        // SB at offset 3
        t = makeTxn(1, 1, 0, 4'h1, 3'd0, 32'h8000_0003, 32'h0000_00AB, 32'h0, 0);
        applyStimulus(t);
        checkOutput("sb_wstrb_literal", 32'(cap_wstrb), 32'h8);
        checkOutput("sb_wdata_literal", cap_wdata, 32'hAB00_0000);
        checkOutput("sb_we_literal", 32'(cap_we), 32'd1);
        checkOutput("sb_regwen_literal", 32'(cap_regwen), 32'd0);

        // LB / LBU at offset 2
        t = makeTxn(1, 0, 1, 4'h1, 3'b000, 32'h8000_0002, 32'h0, 32'h1280_3456, 0);
        applyStimulus(t);
        checkOutput("lb_literal", cap_data, 32'hFFFF_FF80);
        t = makeTxn(1, 0, 1, 4'h1, 3'b100, 32'h8000_0002, 32'h0, 32'h1280_3456, 0);
        applyStimulus(t);
        checkOutput("lbu_literal", cap_data, 32'h0000_0080);

        // Backpressure on request and writeback
        t = makeTxn(1, 0, 1, 4'hF, 3'b010, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 0);
        t.req_delay = 3; t.out_delay = 2;
        applyStimulus(t);
        checkOutput("lw_bp_literal", cap_data, 32'hCAFE_F00D);

        // Bus error on LW at 0
        t = makeTxn(1, 0, 1, 4'hF, 3'b010, 32'h0, 32'h0, 32'h5555_AAAA, 1);
        applyStimulus(t);
        checkOutput("err_flag_literal", 32'(cap_err), 32'd1);
        checkOutput("err_regwen_literal", 32'(cap_regwen), 32'd0);
        checkOutput("err_data_literal", cap_data, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
        t = makeTxn(1, 0, 1, 4'hF, 3'b010, 32'h2, 32'h0, 32'h0, 0);
        applyStimulus(t);
        checkOutput("trap_err_literal", 32'(cap_err), 32'd1);
        checkOutput("trap_no_req", 32'(cap_req_seen), 32'd0);
        checkOutput("trap_regwen_literal", 32'(cap_regwen), 32'd0);
`else
        t = makeTxn(1, 0, 1, 4'h3, 3'b001, 32'h0000_0103, 32'h0, 32'h1234_5678, 0);
        applyStimulus(t);
        checkOutput("lh_wrap_literal", cap_data, 32'h0000_7812);
`endif

        // Reset while waiting for the response, then a stale response
        t = makeTxn(1, 0, 1, 4'hF, 3'b010, 32'h40, 32'h0, 32'h0, 0);
        cur_exp = model(t);
        exp_active = 1'b1;
        need_lsu = 1; mem_wen = 0; mem_ren = 1; load_ctrl = 3'b010; addr_in = 32'h40;
        pc_in = t.pc; rd_in = t.rd; reg_wen_in = 1;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0; req_ready = 1'b1;
        @(posedge clock); #1;
        req_ready = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        exp_active = 1'b0;
        checkOutput("rstw_req_valid", 32'(req_valid), 32'd0);
        checkOutput("rstw_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rstw_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rstw_req_addr", req_addr, 32'd0);
        checkOutput("rstw_pc_out", pc_out, 32'd0);
        checkOutput("rstw_rd_out", 32'(rd_out), 32'd0);
        checkOutput("rstw_regwen", 32'(reg_wen_out), 32'd0);
        checkOutput("rstw_lsu_err", 32'(lsu_err), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        rsp_valid = 1'b1; rsp_rdata = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stale_out_valid", 32'(out_valid), 32'd0);
            checkOutput("stale_out_data", out_data, 32'd0);
            @(posedge clock); #1;
        end

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            t = randTxn();
            applyStimulus(t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
